dircc_output_arbiter: RTL and testbench
=======================================

# dircc_output_arbiter

Packet-granular round-robin arbiter that shares one outgoing Avalon-ST link of a dircc node (north, east, south, west or local-eject) between up to NUM_IN requesting input streams. It runs in the routing clock domain between the per-input route-decode stage and the node output port. Once a packet's startofpacket word wins, the arbiter locks the grant until that packet's endofpacket word has been accepted. This keeps packets contiguous (wormhole switching).

## Interface
- NUM_IN, 5, number of requesting streams (2..8)
- DATA_W, 32, data width
- EMPTY_W, 2, empty-field width
- clk_routing_clk  in  1  routing clock; all logic is on its rising edge
- reset_routing_reset_n  in  1  asynchronous, active-low reset
- in_data  in  NUM_IN*DATA_W  requester data; requester i is in slice [i*DATA_W +: DATA_W]
- in_valid  in  NUM_IN  per-requester valid
- in_ready  out  NUM_IN  per-requester ready
- in_startofpacket  in  NUM_IN  per-requester SOP
- in_endofpacket  in  NUM_IN  per-requester EOP
- in_empty  in  NUM_IN*EMPTY_W  per-requester empty
- out_data  out  DATA_W  granted data
- out_valid  out  1  granted valid
- out_ready  in  1  downstream ready
- out_startofpacket  out  1  granted SOP
- out_endofpacket  out  1  granted EOP
- out_empty  out  EMPTY_W  granted empty
- grant  out  NUM_IN  one-hot current owner; all zero when idle
- drop_count  out  16  saturating count of discarded orphan words

## Operation
- The FSM has two states, IDLE and LOCKED. It resets to IDLE.
- In IDLE, a requester i is eligible when in_valid[i] && in_startofpacket[i].
- The winner is the first eligible index found searching upward (with wrap) from last_grant+1.
- On a win, the FSM enters LOCKED on the next edge. At that edge grant becomes one-hot on the winner and last_grant is set to the winner.
- If no requester is eligible, the FSM stays in IDLE.
- In LOCKED with owner g:
  - out_data, out_valid, out_startofpacket, out_endofpacket and out_empty are combinational copies of requester g's fields.
  - in_ready[g] = out_ready.
  - in_ready for all other requesters is 0.
- A transfer occurs when in_valid[g] && out_ready.
  - A transfer with in_endofpacket[g]=1 returns the FSM to IDLE on the next edge and clears grant.
  - A single-word packet (SOP and EOP both set) therefore holds LOCKED for exactly one transfer.
- Orphan words: in IDLE, any requester with in_valid=1 and in_startofpacket=0 gets in_ready=1 and its word is discarded.
  - drop_count increments by the number of such words in that cycle and saturates at 16'hFFFF.
- In LOCKED, non-owner requesters are held off, whatever they present.
- The arbiter never inspects data and never buffers it. The owner's backpressure from out_ready is passed straight through.

## Timing
- Reset values:
  - state = IDLE, grant = 0, last_grant = NUM_IN-1 (so requester 0 has first priority), drop_count = 0.
  - out_valid = 0, out_startofpacket = 0, out_endofpacket = 0, out_data = 0, out_empty = 0, in_ready = 0 (except the orphan-discard rule).
- Arbitration latency is one cycle: an SOP presented in cycle t can first transfer in cycle t+1.
- Each packet costs one IDLE bubble cycle after its EOP transfer. Best-case throughput is L/(L+1) for L-word packets.
- While IDLE, all out_* are 0.
- Fairness: with all requesters continuously eligible, grants rotate 0,1,...,NUM_IN-1,0,...
- No requester waits more than NUM_IN-1 packets once its SOP is valid.
- If the owner deasserts in_valid mid-packet, out_valid drops and the lock is held; there is no timeout.
- A reset assertion mid-packet clears all state immediately, without waiting for a clock. out_valid falls with reset.
- After reset release, arbitration restarts from requester 0. The tail of the interrupted packet arrives without SOP and is discarded as orphan words.

## Test plan
- Single requester 2, 4-word packet, out_ready=1 -> grant=5'b00100 from cycle 1; words 1-4 appear on out in cycles 1-4 with SOP on word 1 and EOP on word 4; grant=0 in cycle 5.
- All 5 requesters hold 1-word packets continuously -> grant sequence 0,1,2,3,4,0, with one idle cycle between grants.
- Requester 1 is locked on a 3-word packet while requester 0 raises SOP -> in_ready[0]=0 until requester 1's EOP transfers; requester 0 is granted next, with no interleaving.
- out_ready toggles 1,0,1,0 during a locked packet -> in_ready[g] mirrors out_ready; no word is lost or duplicated; all 3 words are delivered in order.
- Requester 3 presents 3 valid words with SOP=0 while idle -> all accepted and discarded; drop_count=3; out_valid stays 0.
- Reset asserted after word 2 of a 4-word packet -> out_valid=0 and grant=0 immediately; after release, words 3-4 (no SOP) are dropped and drop_count=2.

Source files
------------

// File: rtl/dircc_output_arbiter_if.sv
// Avalon-ST bundle between NUM_IN requesters, the output arbiter and the node output port,
// plus the arbiter's observable grant and orphan-drop counter.
interface dircc_output_arbiter_if #(
  parameter int NUM_IN  = 5,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);
  // Handshake: a word moves on a rising edge exactly when valid and ready are both high
  // in the cycle before it; ready may depend combinationally on valid, never the reverse.
  logic [NUM_IN*DATA_W-1:0]  in_data;
  logic [NUM_IN-1:0]         in_valid;
  logic [NUM_IN-1:0]         in_ready;
  logic [NUM_IN-1:0]         in_startofpacket;
  logic [NUM_IN-1:0]         in_endofpacket;
  logic [NUM_IN*EMPTY_W-1:0] in_empty;

  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_startofpacket;
  logic                      out_endofpacket;
  logic [EMPTY_W-1:0]        out_empty;

  logic [NUM_IN-1:0]         grant;
  logic [15:0]               drop_count;

  modport master (
    output in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, out_ready,
    input  in_ready, out_data, out_valid, out_startofpacket, out_endofpacket, out_empty,
           grant, drop_count
  );

  modport slave (
    input  in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, out_ready,
    output in_ready, out_data, out_valid, out_startofpacket, out_endofpacket, out_empty,
           grant, drop_count
  );
endinterface

// File: rtl/dircc_output_arbiter.sv
// Packet-granular round-robin arbiter for one dircc node output link: the SOP winner
// keeps the link until its EOP word is accepted; stray non-SOP words are dropped while idle.
module dircc_output_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
) (
  input  logic                 clk_routing_clk,
  input  logic                 reset_routing_reset_n,
  dircc_output_arbiter_if.slave bus,
  output logic                 state_dbg_o
);
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [15:0]      drop_q, drop_d;

  logic [NUM_IN-1:0]  eligible;
  logic [NUM_IN-1:0]  orphan;
  logic [NUM_IN-1:0]  owner_oh;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [3:0]         orphan_cnt;
  logic [16:0]        drop_sum;
  logic [DATA_W-1:0]  own_data;
  logic [EMPTY_W-1:0] own_empty;
  logic               own_valid, own_sop, own_eop;

  assign eligible = bus.in_valid & bus.in_startofpacket;
  assign orphan   = bus.in_valid & ~bus.in_startofpacket;
  assign owner_oh = NUM_IN'(1) << last_q;

  // last_q doubles as the owner index while LOCKED
  assign own_data  = bus.in_data[int'(last_q)*DATA_W +: DATA_W];
  assign own_empty = bus.in_empty[int'(last_q)*EMPTY_W +: EMPTY_W];
  assign own_valid = bus.in_valid[last_q];
  assign own_sop   = bus.in_startofpacket[last_q];
  assign own_eop   = bus.in_endofpacket[last_q];

  // Search upward from last_q+1 with wrap, so the previous winner has lowest priority
  always_comb begin : winner_search
    int c;
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= NUM_IN; k++) begin
      c = int'(last_q) + k;
      if (c >= NUM_IN) c = c - NUM_IN;
      if (!win_found && eligible[c]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(c);
      end
    end
  end

  always_comb begin : orphan_count
    orphan_cnt = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      orphan_cnt = orphan_cnt + 4'(orphan[i]);
    end
    drop_sum = {1'b0, drop_q} + 17'(orphan_cnt);
  end

  always_comb begin : fsm_next
    state_d               = state_q;
    last_d                = last_q;
    drop_d                = drop_q;
    bus.in_ready          = '0;
    bus.grant             = '0;
    bus.out_data          = '0;
    bus.out_valid         = 1'b0;
    bus.out_startofpacket = 1'b0;
    bus.out_endofpacket   = 1'b0;
    bus.out_empty         = '0;
    case (state_q)
      IDLE: begin
        bus.in_ready = orphan;
        drop_d       = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (win_found) begin
          state_d = LOCKED;
          last_d  = win_idx;
        end
      end
      LOCKED: begin
        bus.grant             = owner_oh;
        bus.out_data          = own_data;
        bus.out_valid         = own_valid;
        bus.out_startofpacket = own_sop;
        bus.out_endofpacket   = own_eop;
        bus.out_empty         = own_empty;
        bus.in_ready          = owner_oh & {NUM_IN{bus.out_ready}};
        if (own_valid && bus.out_ready && own_eop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_routing_clk or negedge reset_routing_reset_n) begin
    if (!reset_routing_reset_n) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_IN - 1);
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.drop_count = drop_q;
  assign state_dbg_o    = (state_q == LOCKED);
endmodule

// File: tb/tb_dircc_output_arbiter.sv
// Bench for dircc_output_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic against a packet-level reference model.
`timescale 1ns/1ps
module tb_dircc_output_arbiter;
  localparam int NUM_IN  = 5;
  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;

  // ---------------- clock / reset ----------------
  logic clk_routing_clk = 1'b0;
  logic reset_routing_reset_n = 1'b0;
  logic state_dbg;
  always #5 clk_routing_clk = ~clk_routing_clk;

  dircc_output_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) arb_if ();

  dircc_output_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) dut (
    .clk_routing_clk       (clk_routing_clk),
    .reset_routing_reset_n (reset_routing_reset_n),
    .bus                   (arb_if.slave),
    .state_dbg_o           (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [NUM_IN-1:0] tv, ts, te;
  logic [DATA_W-1:0] td [NUM_IN];
  logic              t_ordy;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] got_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_inputs();
    arb_if.in_valid         = tv;
    arb_if.in_startofpacket = ts;
    arb_if.in_endofpacket   = te;
    arb_if.out_ready        = t_ordy;
    for (int i = 0; i < NUM_IN; i++) begin
      arb_if.in_data[i*DATA_W +: DATA_W]    = td[i];
      arb_if.in_empty[i*EMPTY_W +: EMPTY_W] = EMPTY_W'(i);
    end
  endtask

  task automatic clear_inputs();
    tv = '0; ts = '0; te = '0; t_ordy = 1'b1;
    for (int i = 0; i < NUM_IN; i++) td[i] = '0;
    push_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_routing_reset_n = 1'b0;
    repeat (2) @(posedge clk_routing_clk);
    @(negedge clk_routing_clk);
    reset_routing_reset_n = 1'b1;
    @(posedge clk_routing_clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk_routing_clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [NUM_IN-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < NUM_IN; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [NUM_IN-1:0] v, s, e;
    logic              ordy;
    logic [NUM_IN-1:0] x_grant, x_ready;
    logic [2:0]        x_out;   // {valid, sop, eop}
    logic [15:0]       x_drop;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic [4:0] v, s, e, input logic o,
                              input logic [4:0] g, r, input logic [2:0] x, input logic [15:0] d);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.ordy = o;
    t.x_grant = g; t.x_ready = r; t.x_out = x; t.x_drop = d;
    return t;
  endfunction

  // ---------------- reference model state ----------------
  int                m_locked, m_owner, m_last, m_drop, m_cnt, m_c;
  logic [NUM_IN-1:0] m_grant, m_ready;
  logic              m_ovalid;
  logic [DATA_W-1:0] m_odata;
  int                widx [NUM_IN];
  int                plen [NUM_IN];
  logic              stray [NUM_IN];
  int                seq;
  int                w;
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] got_word;
  logic [DATA_W-1:0] exp_data;

  initial begin
    clear_inputs();
    reset_routing_reset_n = 1'b0;
    #12;
    check("reset_grant", 64'(arb_if.grant), 64'(0));
    check("reset_out_valid", 64'(arb_if.out_valid), 64'(0));
    check("reset_out_data", 64'(arb_if.out_data), 64'(0));
    check("reset_drop", 64'(arb_if.drop_count), 64'(0));
    check("reset_state", 64'(state_dbg), 64'(0));
    check("reset_in_ready", 64'(arb_if.in_ready), 64'(0));

    // ---- table: requester 2 sends a 4-word packet, then requester 3 sends 3 orphans ----
    tbl[0] = mk(5'b00100, 5'b00100, 5'b00000, 1, 5'b00000, 5'b00000, 3'b000, 0);
    tbl[1] = mk(5'b00100, 5'b00100, 5'b00000, 1, 5'b00100, 5'b00100, 3'b110, 0);
    tbl[2] = mk(5'b00100, 5'b00000, 5'b00000, 1, 5'b00100, 5'b00100, 3'b100, 0);
    tbl[3] = mk(5'b00100, 5'b00000, 5'b00000, 1, 5'b00100, 5'b00100, 3'b100, 0);
    tbl[4] = mk(5'b00100, 5'b00000, 5'b00100, 1, 5'b00100, 5'b00100, 3'b101, 0);
    tbl[5] = mk(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 3'b000, 0);
    tbl[6] = mk(5'b01000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b01000, 3'b000, 0);
    tbl[7] = mk(5'b01000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b01000, 3'b000, 1);
    tbl[8] = mk(5'b01000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b01000, 3'b000, 2);
    tbl[9] = mk(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 3'b000, 3);

    do_reset();
    for (int r = 0; r < 10; r++) begin
      tv = tbl[r].v; ts = tbl[r].s; te = tbl[r].e; t_ordy = tbl[r].ordy;
      for (int i = 0; i < NUM_IN; i++) td[i] = DATA_W'(i * 256 + r);
      push_inputs();
      @(negedge clk_routing_clk);
      exp_data = tbl[r].x_out[2] ? DATA_W'(oh2idx(tbl[r].x_grant) * 256 + r) : '0;
      check($sformatf("tbl%0d_grant", r), 64'(arb_if.grant), 64'(tbl[r].x_grant));
      check($sformatf("tbl%0d_in_ready", r), 64'(arb_if.in_ready), 64'(tbl[r].x_ready));
      check($sformatf("tbl%0d_out_flags", r),
            64'({arb_if.out_valid, arb_if.out_startofpacket, arb_if.out_endofpacket}),
            64'(tbl[r].x_out));
      check($sformatf("tbl%0d_drop", r), 64'(arb_if.drop_count), 64'(tbl[r].x_drop));
      check($sformatf("tbl%0d_out_data", r), 64'(arb_if.out_data), 64'(exp_data));
      if (tbl[r].x_out[2])
        check($sformatf("tbl%0d_out_empty", r), 64'(arb_if.out_empty),
              64'(oh2idx(tbl[r].x_grant) % 4));
      next_cycle();
    end

    // ---- fairness: every requester holds single-word packets ----
    do_reset();
    tv = '1; ts = '1; te = '1; t_ordy = 1'b1;
    push_inputs();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_routing_clk);
      check($sformatf("rr_grant_c%0d", c), 64'(arb_if.grant),
            (c % 2 == 1) ? 64'(1) << ((c / 2) % NUM_IN) : 64'(0));
      check($sformatf("rr_valid_c%0d", c), 64'(arb_if.out_valid), 64'(c % 2));
      next_cycle();
    end

    // ---- requester 1 locked on 3 words while requester 0 raises SOP ----
    do_reset();
    tv = 5'b00010; ts = 5'b00010; te = '0;
    push_inputs();
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      tv = 5'b00011; ts = {3'b000, (c == 1), 1'b1}; te = {3'b000, (c == 3), 1'b0};
      push_inputs();
      @(negedge clk_routing_clk);
      check($sformatf("hold_grant_w%0d", c), 64'(arb_if.grant), 64'(5'b00010));
      check($sformatf("hold_in_ready_w%0d", c), 64'(arb_if.in_ready), 64'(5'b00010));
      next_cycle();
    end
    tv = 5'b00001; ts = 5'b00001; te = 5'b00001;
    push_inputs();
    @(negedge clk_routing_clk);
    check("hold_bubble_grant", 64'(arb_if.grant), 64'(0));
    check("hold_bubble_ready", 64'(arb_if.in_ready), 64'(0));
    next_cycle();
    @(negedge clk_routing_clk);
    check("hold_next_grant", 64'(arb_if.grant), 64'(5'b00001));
    check("hold_next_ready", 64'(arb_if.in_ready), 64'(5'b00001));
    next_cycle();

    // ---- out_ready toggling during a 3-word packet on requester 4 ----
    do_reset();
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back(DATA_W'(32'hA0 + k));
    w = 0;
    for (int c = 0; c < 20 && w < 3; c++) begin
      tv = 5'b10000; ts = {(w == 0), 4'b0000}; te = {(w == 2), 4'b0000};
      td[4] = DATA_W'(32'hA0 + w);
      t_ordy = (c == 0) ? 1'b1 : 1'(c % 2);
      push_inputs();
      @(negedge clk_routing_clk);
      if (c >= 1)
        check($sformatf("tog_ready_c%0d", c), 64'(arb_if.in_ready[4]), 64'(t_ordy));
      if (arb_if.out_valid && arb_if.out_ready) got_q.push_back(arb_if.out_data);
      if (arb_if.in_ready[4]) w++;
      next_cycle();
    end
    check("tog_all_words_accepted", 64'(w), 64'(3));
    check("tog_word_count", 64'(got_q.size()), 64'(3));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      got_word = got_q.pop_front();
      check("tog_word", 64'(got_word), 64'(exp_word));
    end
    clear_inputs();

    // ---- reset asserted mid-packet on requester 2 ----
    do_reset();
    tv = 5'b00100; ts = 5'b00100; te = '0; td[2] = 32'hB1; t_ordy = 1'b1;
    push_inputs();
    next_cycle();
    next_cycle();
    ts = '0; td[2] = 32'hB2;
    push_inputs();
    next_cycle();
    td[2] = 32'hB3;
    push_inputs();
    #1;
    check("rstmid_valid_before", 64'(arb_if.out_valid), 64'(1));
    reset_routing_reset_n = 1'b0;
    #1;
    check("rstmid_valid_now", 64'(arb_if.out_valid), 64'(0));
    check("rstmid_grant_now", 64'(arb_if.grant), 64'(0));
    @(negedge clk_routing_clk);
    reset_routing_reset_n = 1'b1;
    #1;
    check("rstmid_w3_dropped", 64'(arb_if.in_ready), 64'(5'b00100));
    next_cycle();
    td[2] = 32'hB4; te = 5'b00100;
    push_inputs();
    #1;
    check("rstmid_w4_dropped", 64'(arb_if.in_ready), 64'(5'b00100));
    check("rstmid_w4_no_out", 64'(arb_if.out_valid), 64'(0));
    next_cycle();
    clear_inputs();
    #1;
    check("rstmid_drop", 64'(arb_if.drop_count), 64'(2));

    // ---- drop_count saturation: five orphans per cycle ----
    do_reset();
    tv = '1; ts = '0; te = '0;
    push_inputs();
    repeat (13106) @(posedge clk_routing_clk);
    #1;
    check("sat_drop_65530", 64'(arb_if.drop_count), 64'(65530));
    next_cycle();
    check("sat_drop_max", 64'(arb_if.drop_count), 64'(16'hFFFF));
    next_cycle();
    check("sat_drop_hold", 64'(arb_if.drop_count), 64'(16'hFFFF));
    clear_inputs();

    // ---- randomized traffic against the packet-level model ----
    do_reset();
    exp_q.delete();
    m_locked = 0; m_owner = 0; m_last = NUM_IN - 1; m_drop = 0; seq = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      widx[i] = 0; plen[i] = $urandom_range(1, 4); stray[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        tv[i] = ($urandom_range(0, 3) != 0);
        if (widx[i] == 0) begin
          stray[i] = ($urandom_range(0, 9) == 0);
          ts[i] = !stray[i];
          te[i] = !stray[i] && (plen[i] == 1);
        end else begin
          ts[i] = 1'b0;
          te[i] = (widx[i] == plen[i] - 1);
        end
        seq++;
        td[i] = {8'(i), 8'(widx[i]), 16'(seq)};
      end
      t_ordy = ($urandom_range(0, 3) != 0);
      push_inputs();

      @(negedge clk_routing_clk);
      m_grant = '0; m_ready = '0; m_ovalid = 1'b0; m_odata = '0;
      if (m_locked == 0) begin
        m_ready = tv & ~ts;
      end else begin
        m_grant[m_owner] = 1'b1;
        m_ready[m_owner] = t_ordy;
        m_ovalid = tv[m_owner];
        m_odata  = td[m_owner];
        if (tv[m_owner] && t_ordy) exp_q.push_back(td[m_owner]);
      end
      check("rnd_grant", 64'(arb_if.grant), 64'(m_grant));
      check("rnd_in_ready", 64'(arb_if.in_ready), 64'(m_ready));
      check("rnd_out_valid", 64'(arb_if.out_valid), 64'(m_ovalid));
      check("rnd_drop", 64'(arb_if.drop_count), 64'(m_drop));
      if (arb_if.out_valid && arb_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_word", 64'(arb_if.out_data), 64'(m_odata) ^ 64'(1));
        end else begin
          exp_word = exp_q.pop_front();
          check("rnd_word", 64'(arb_if.out_data), 64'(exp_word));
        end
      end

      @(posedge clk_routing_clk);
      if (m_locked == 0) begin
        m_cnt = 0;
        for (int i = 0; i < NUM_IN; i++) m_cnt += int'(m_ready[i]);
        m_drop = (m_drop + m_cnt > 65535) ? 65535 : m_drop + m_cnt;
        for (int k = 1; k <= NUM_IN; k++) begin
          m_c = (m_last + k) % NUM_IN;
          if (m_locked == 0 && tv[m_c] && ts[m_c]) begin
            m_locked = 1; m_owner = m_c; m_last = m_c;
          end
        end
      end else if (tv[m_owner] && t_ordy && te[m_owner]) begin
        m_locked = 0;
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (tv[i] && m_ready[i] && !stray[i]) begin
          widx[i]++;
          if (widx[i] == plen[i]) begin
            widx[i] = 0;
            plen[i] = $urandom_range(1, 4);
          end
        end
      end
      #1;
    end
    check("rnd_scoreboard_empty", 64'(exp_q.size()), 64'(0));

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
